microcode_controller: RTL and testbench

- Next-address controller sitting between the registered control-store output (current microword) and the 12-bit microprogram sequencer.
- Each cycle it turns the microword's next-control field, condition inputs, the memory wait handshake and trap requests into sequencer op/relative/din.
- Tracks the sequencer's 4-deep return stack to detect overflow/underflow, which the sequencer itself silently wraps.
- Enforces a wait-state timeout.

---
 rtl/microcode_pkg.sv | 36 +++
 rtl/microcode_if.sv | 42 ++++
 rtl/microcode_cond_select.sv | 21 ++
 rtl/microcode_controller.sv | 200 ++++++++++++++++++++
 tb/tb_microcode_controller.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microcode_pkg.sv
// -----------------------------------------------------------------------------
// microcode_pkg
// Shared encodings for the microcode next-address controller: sequencer op
// codes, the HOLD displacement, controller state, decode action and fault codes.
// -----------------------------------------------------------------------------
package microcode_pkg;

    // Sequencer op encodings (also used for the microword's own op field).
    localparam logic [1:0] SEQ_NEXT = 2'd0;
    localparam logic [1:0] SEQ_JUMP = 2'd1;
    localparam logic [1:0] SEQ_CALL = 2'd2;
    localparam logic [1:0] SEQ_RET  = 2'd3;

    // Relative jump by -1 from pc=A+1 lands back on A: the HOLD command.
    localparam logic [11:0] HOLD_DISP = 12'hFFF;

    // Sticky fault codes.
    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_OVF     = 2'd1;
    localparam logic [1:0] FAULT_UNF     = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } state_e;

    // What the controller presents to the sequencer this cycle.
    typedef enum logic [1:0] {
        ACT_PASS = 2'd0,   // effective microword op, uw_rel, uw_addr
        ACT_HOLD = 2'd1,   // re-present the current microword
        ACT_TRAP = 2'd2    // absolute call to the trap vector
    } action_e;

endpackage

// File: rtl/microcode_if.sv
// -----------------------------------------------------------------------------
// microcode_if
// Bundles the current microword fields, datapath/handshake inputs, the
// sequencer command outputs and the controller status outputs.
//   master : drives microword / cond / wait_req / trap_req, observes the rest
//   slave  : the controller (consumes microword, drives seq_* and status)
// -----------------------------------------------------------------------------
interface microcode_if #(
    parameter int ADDR_W = 12
);
    // Current microword (registered control-store output)
    logic [1:0]        uw_op;
    logic              uw_rel;
    logic [ADDR_W-1:0] uw_addr;
    logic [2:0]        uw_cond_sel;
    logic              uw_cond_inv;
    logic              uw_wait;
    // Datapath / handshake inputs
    logic [7:0]        cond;
    logic              wait_req;
    logic              trap_req;
    // Sequencer command
    logic [1:0]        seq_op;
    logic              seq_rel;
    logic [ADDR_W-1:0] seq_din;
    // Status
    logic              trap_ack;
    logic [2:0]        depth;
    logic [1:0]        fault;

    modport master (
        output uw_op, uw_rel, uw_addr, uw_cond_sel, uw_cond_inv, uw_wait,
        output cond, wait_req, trap_req,
        input  seq_op, seq_rel, seq_din, trap_ack, depth, fault
    );

    modport slave (
        input  uw_op, uw_rel, uw_addr, uw_cond_sel, uw_cond_inv, uw_wait,
        input  cond, wait_req, trap_req,
        output seq_op, seq_rel, seq_din, trap_ack, depth, fault
    );
endinterface

// File: rtl/microcode_cond_select.sv
// -----------------------------------------------------------------------------
// microcode_cond_select
// Combinational condition mux with optional inversion.
//   cond_sel  in  3 : 0 selects constant true, 1..7 select cond[1..7]
//   cond_inv  in  1 : invert the selected condition
//   cond      in  8 : datapath flags (bit 0 is never selected)
//   cond_true out 1 : resulting branch condition
// -----------------------------------------------------------------------------
module microcode_cond_select (
    input  logic [2:0] cond_sel,
    input  logic       cond_inv,
    input  logic [7:0] cond,
    output logic       cond_true
);
    logic selected;

    always_comb begin
        selected  = (cond_sel == 3'd0) ? 1'b1 : cond[cond_sel];
        cond_true = selected ^ cond_inv;
    end
endmodule

// File: rtl/microcode_controller.sv
// -----------------------------------------------------------------------------
// microcode_controller
// Next-address controller between the control-store output register and the
// 12-bit microprogram sequencer. Turns the current microword's next-control
// field, conditions, wait handshake and trap requests into sequencer commands,
// shadows the sequencer's return-stack depth to catch overflow/underflow, and
// times out over-long wait stalls.
//   clock     in  : system clock
//   reset     in  : asynchronous, active-low
//   bus       slave modport of microcode_if:
//     seq_op/seq_rel/seq_din : combinational sequencer command (zero latency)
//     trap_ack/depth/fault   : registered status
// trap_ack is registered, so it is high in the cycle after the trap call is
// presented to the sequencer, for exactly one cycle.
// -----------------------------------------------------------------------------
module microcode_controller
    import microcode_pkg::*;
#(
    parameter int                ADDR_W      = 12,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 12'h010,
    parameter int                WAIT_LIMIT  = 255
) (
    input  logic         clock,
    input  logic         reset,
    microcode_if.slave   bus
);
    localparam int                CNT_W      = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [2:0]        DEPTH_FULL = 3'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] HOLD_DIN   = ADDR_W'(HOLD_DISP);

    // Registered state
    state_e           state_q,      state_d;
    logic [2:0]       depth_q,      depth_d;
    logic [1:0]       fault_q,      fault_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic             in_trap_q,    in_trap_d;
    logic [2:0]       trap_depth_q, trap_depth_d;
    logic             trap_ack_q,   trap_ack_d;

    // Decode
    logic       cond_true;
    logic [1:0] eff_op;
    action_e    action;
    logic [1:0] fault_evt;
    logic       evaluate;

    microcode_cond_select u_cond_select (
        .cond_sel  (bus.uw_cond_sel),
        .cond_inv  (bus.uw_cond_inv),
        .cond      (bus.cond),
        .cond_true (cond_true)
    );

    // A failed condition turns any op into a plain sequential step.
    assign eff_op = cond_true ? bus.uw_op : SEQ_NEXT;

    // Decide this cycle's action and whether it raises a fault.
    always_comb begin
        action    = ACT_PASS;
        fault_evt = FAULT_NONE;
        evaluate  = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.uw_wait && bus.wait_req) begin
                    action = ACT_HOLD;
                end else begin
                    evaluate = 1'b1;
                end
            end
            STALL: begin
                // Only wait_req matters while stalled; a trap request cannot
                // break the stall but is honoured on the release cycle.
                if (bus.wait_req) begin
                    action = ACT_HOLD;
                    if (stall_cnt_q == CNT_LIMIT) begin
                        fault_evt = FAULT_TIMEOUT;
                    end
                end else begin
                    evaluate = 1'b1;
                end
            end
            default: begin
                action = ACT_HOLD;
            end
        endcase

        if (evaluate) begin
            if (eff_op == SEQ_CALL && depth_q == DEPTH_FULL) begin
                action    = ACT_HOLD;
                fault_evt = FAULT_OVF;
            end else if (eff_op == SEQ_RET && depth_q == 3'd0) begin
                action    = ACT_HOLD;
                fault_evt = FAULT_UNF;
            end else if (eff_op == SEQ_NEXT && bus.trap_req && !in_trap_q
                         && depth_q < DEPTH_FULL) begin
                action = ACT_TRAP;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        fault_d      = fault_q;
        stall_cnt_d  = stall_cnt_q;
        in_trap_d    = in_trap_q;
        trap_depth_d = trap_depth_q;
        trap_ack_d   = 1'b0;

        if (fault_evt != FAULT_NONE) begin
            state_d = FAULT;
            fault_d = fault_evt;
        end else if (state_q != FAULT) begin
            case (action)
                ACT_HOLD: begin
                    // Only a wait can hold without faulting.
                    state_d = STALL;
                    if (state_q == RUN) begin
                        stall_cnt_d = CNT_W'(1);
                    end else if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end
                ACT_TRAP: begin
                    state_d      = RUN;
                    stall_cnt_d  = '0;
                    depth_d      = depth_q + 3'd1;
                    in_trap_d    = 1'b1;
                    trap_depth_d = depth_q;
                    trap_ack_d   = 1'b1;
                end
                default: begin
                    state_d     = RUN;
                    stall_cnt_d = '0;
                    if (eff_op == SEQ_CALL) begin
                        depth_d = depth_q + 3'd1;
                    end else if (eff_op == SEQ_RET) begin
                        depth_d = depth_q - 3'd1;
                        // Popping the trap frame ends the trap handler.
                        if (in_trap_q && (depth_q - 3'd1) == trap_depth_q) begin
                            in_trap_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            depth_q      <= 3'd0;
            fault_q      <= FAULT_NONE;
            stall_cnt_q  <= '0;
            in_trap_q    <= 1'b0;
            trap_depth_q <= 3'd0;
            trap_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            stall_cnt_q  <= stall_cnt_d;
            in_trap_q    <= in_trap_d;
            trap_depth_q <= trap_depth_d;
            trap_ack_q   <= trap_ack_d;
        end
    end

    // Output logic
    always_comb begin
        case (action)
            ACT_HOLD: begin
                bus.seq_op  = SEQ_JUMP;
                bus.seq_rel = 1'b1;
                bus.seq_din = HOLD_DIN;
            end
            ACT_TRAP: begin
                bus.seq_op  = SEQ_CALL;
                bus.seq_rel = 1'b0;
                bus.seq_din = TRAP_VECTOR;
            end
            default: begin
                bus.seq_op  = eff_op;
                bus.seq_rel = bus.uw_rel;
                bus.seq_din = bus.uw_addr;
            end
        endcase
    end

    assign bus.trap_ack = trap_ack_q;
    assign bus.depth    = depth_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_microcode_controller.sv
// -----------------------------------------------------------------------------
// tb_microcode_controller
// Directed stimulus with a behavioural reference model (explicit return stack
// with tagged trap frames, stall length counted in held cycles) checked every
// falling clock edge, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_microcode_controller;
    localparam int WAIT_LIMIT = 255;
    localparam int STACK_DEPTH = 4;
    localparam logic [11:0] TRAP_VEC = 12'h010;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    microcode_if #(.ADDR_W(12)) bus ();

    microcode_controller #(
        .ADDR_W      (12),
        .STACK_DEPTH (STACK_DEPTH),
        .TRAP_VECTOR (TRAP_VEC),
        .WAIT_LIMIT  (WAIT_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_mode = 0;          // 0 running, 1 stalled, 2 faulted
    bit   m_stack[$];          // one entry per live return address, 1 = trap frame
    int   m_stall_len = 0;     // held cycles in the current stall, including this one
    bit   m_ack = 1'b0;
    logic [1:0] m_fault = 2'd0;

    function automatic bit m_in_trap();
        foreach (m_stack[i]) if (m_stack[i]) return 1'b1;
        return 1'b0;
    endfunction

    logic       e_c;
    logic [1:0] e_eff;
    int         e_kind;        // 0 pass, 1 hold, 2 trap
    bit         e_ack_next;

    always @(negedge clock) begin
        if (!reset) begin
            m_mode = 0; m_stack.delete(); m_stall_len = 0; m_ack = 1'b0; m_fault = 2'd0;
            check("rst_trap_ack", 32'(bus.trap_ack), 0);
            check("rst_depth",    32'(bus.depth),    0);
            check("rst_fault",    32'(bus.fault),    0);
        end else begin
            check("trap_ack", 32'(bus.trap_ack), 32'(m_ack));
            check("depth",    32'(bus.depth),    m_stack.size());
            check("fault",    32'(bus.fault),    32'(m_fault));

            e_c   = ((bus.uw_cond_sel == 3'd0) ? 1'b1 : bus.cond[bus.uw_cond_sel]) ^ bus.uw_cond_inv;
            e_eff = e_c ? bus.uw_op : 2'd0;
            e_kind = 0;
            e_ack_next = 1'b0;

            if (m_mode == 2) begin
                e_kind = 1;
            end else if (m_mode == 1 && bus.wait_req) begin
                e_kind = 1;
                m_stall_len++;
                if (m_stall_len == WAIT_LIMIT + 1) begin
                    m_fault = 2'd3; m_mode = 2;
                end
            end else if (m_mode == 0 && bus.uw_wait && bus.wait_req) begin
                e_kind = 1; m_mode = 1; m_stall_len = 1;
            end else begin
                m_mode = 0; m_stall_len = 0;
                if (e_eff == 2'd2 && m_stack.size() == STACK_DEPTH) begin
                    e_kind = 1; m_fault = 2'd1; m_mode = 2;
                end else if (e_eff == 2'd3 && m_stack.size() == 0) begin
                    e_kind = 1; m_fault = 2'd2; m_mode = 2;
                end else if (e_eff == 2'd0 && bus.trap_req && !m_in_trap()
                             && m_stack.size() < STACK_DEPTH) begin
                    e_kind = 2; m_stack.push_back(1'b1); e_ack_next = 1'b1;
                end else begin
                    if (e_eff == 2'd2) m_stack.push_back(1'b0);
                    if (e_eff == 2'd3) void'(m_stack.pop_back());
                end
            end

            case (e_kind)
                1: begin
                    check("seq_op_hold",  32'(bus.seq_op),  1);
                    check("seq_rel_hold", 32'(bus.seq_rel), 1);
                    check("seq_din_hold", 32'(bus.seq_din), 32'hFFF);
                end
                2: begin
                    check("seq_op_trap",  32'(bus.seq_op),  2);
                    check("seq_rel_trap", 32'(bus.seq_rel), 0);
                    check("seq_din_trap", 32'(bus.seq_din), 32'(TRAP_VEC));
                end
                default: begin
                    check("seq_op",  32'(bus.seq_op),  32'(e_eff));
                    check("seq_rel", 32'(bus.seq_rel), 32'(bus.uw_rel));
                    check("seq_din", 32'(bus.seq_din), 32'(bus.uw_addr));
                end
            endcase
            m_ack = e_ack_next;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] op, input logic rel, input logic [11:0] addr,
                         input logic [2:0] sel, input logic inv, input logic wt);
        bus.uw_op = op; bus.uw_rel = rel; bus.uw_addr = addr;
        bus.uw_cond_sel = sel; bus.uw_cond_inv = inv; bus.uw_wait = wt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        check("lit_rst_depth", 32'(bus.depth), 0);
        check("lit_rst_fault", 32'(bus.fault), 0);
        tick();
        reset = 1'b1;
    endtask

    task automatic expect_hold(input string name);
        check(name, {bus.seq_op, bus.seq_rel, bus.seq_din}, {2'd1, 1'b1, 12'hFFF});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        drive(2'd0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
        bus.cond = 8'h00; bus.wait_req = 1'b0; bus.trap_req = 1'b0;
        tick(); tick();
        reset = 1'b1;

        // Straight-line microwords
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 1'b0, 12'(i), 3'd0, 1'b0, 1'b0);
            #2 check("lit_line_op", 32'(bus.seq_op), 0);
            tick();
        end
        check("lit_line_depth", 32'(bus.depth), 0);

        // Conditional jump
        drive(2'd1, 1'b0, 12'h123, 3'd3, 1'b0, 1'b0);
        #2 check("lit_cj_false", 32'(bus.seq_op), 0);
        tick();
        bus.cond = 8'h08;
        #2 check("lit_cj_true", {bus.seq_op, bus.seq_din}, {2'd1, 12'h123});
        tick();
        drive(2'd1, 1'b0, 12'h123, 3'd3, 1'b1, 1'b0);
        #2 check("lit_cj_inv_true", 32'(bus.seq_op), 0);
        tick();
        bus.cond = 8'h00;
        #2 check("lit_cj_inv_false", 32'(bus.seq_op), 1);
        tick();

        // Nested calls to overflow
        for (int i = 1; i <= 4; i++) begin
            drive(2'd2, 1'b0, 12'h200 + 12'(i), 3'd0, 1'b0, 1'b0);
            #2 check("lit_call_op", 32'(bus.seq_op), 2);
            tick();
            check("lit_call_depth", 32'(bus.depth), i);
        end
        drive(2'd2, 1'b0, 12'h205, 3'd0, 1'b0, 1'b0);
        #2 expect_hold("lit_ovf_hold");
        tick();
        check("lit_ovf_fault", 32'(bus.fault), 1);
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 1'b0, 12'h300, 3'd0, 1'b0, 1'b0);
            #2 expect_hold("lit_fault_hold");
            tick();
        end
        check("lit_frozen_depth", 32'(bus.depth), 4);
        reset_pulse();

        // Wait held for 3 cycles
        drive(2'd1, 1'b0, 12'h055, 3'd0, 1'b0, 1'b1);
        bus.wait_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 expect_hold("lit_wait_hold");
            tick();
        end
        bus.wait_req = 1'b0;
        #2 check("lit_wait_release", {bus.seq_op, bus.seq_rel, bus.seq_din}, {2'd1, 1'b0, 12'h055});
        tick();

        // 255 stalled cycles: no timeout yet
        drive(2'd0, 1'b0, 12'h060, 3'd0, 1'b0, 1'b1);
        bus.wait_req = 1'b1;
        repeat (255) tick();
        check("lit_wait255_fault", 32'(bus.fault), 0);
        bus.wait_req = 1'b0;
        tick();
        check("lit_wait255_after", 32'(bus.fault), 0);

        // 256 stalled cycles: timeout
        bus.wait_req = 1'b1;
        repeat (256) tick();
        check("lit_timeout_fault", 32'(bus.fault), 3);
        bus.wait_req = 1'b0;
        #2 expect_hold("lit_timeout_hold");
        tick();
        reset_pulse();

        // Traps
        bus.trap_req = 1'b1;
        drive(2'd1, 1'b0, 12'h300, 3'd0, 1'b0, 1'b0);
        #2 check("lit_trap_on_jump", 32'(bus.seq_op), 1);
        tick();
        check("lit_no_ack_jump", 32'(bus.trap_ack), 0);
        drive(2'd0, 1'b0, 12'h301, 3'd0, 1'b0, 1'b0);
        #2 check("lit_trap_call", {bus.seq_op, bus.seq_rel, bus.seq_din}, {2'd2, 1'b0, 12'h010});
        tick();
        check("lit_trap_ack", {29'd0, bus.trap_ack, bus.depth}, {29'd0, 1'b1, 3'd1});
        drive(2'd0, 1'b0, 12'h011, 3'd0, 1'b0, 1'b0);
        #2 check("lit_trap_nested_ignored", 32'(bus.seq_op), 0);
        tick();
        check("lit_ack_one_cycle", 32'(bus.trap_ack), 0);
        drive(2'd2, 1'b0, 12'h400, 3'd0, 1'b0, 1'b0); tick();
        drive(2'd0, 1'b0, 12'h401, 3'd0, 1'b0, 1'b0); tick();
        drive(2'd3, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); tick();
        drive(2'd0, 1'b0, 12'h012, 3'd0, 1'b0, 1'b0);
        #2 check("lit_still_in_trap", 32'(bus.seq_op), 0);
        tick();
        drive(2'd3, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); tick();
        check("lit_trap_exit_depth", 32'(bus.depth), 0);
        drive(2'd0, 1'b0, 12'h302, 3'd0, 1'b0, 1'b0);
        #2 check("lit_retrap", 32'(bus.seq_op), 2);
        tick();
        drive(2'd3, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); tick();
        bus.cond = 8'h20;
        drive(2'd1, 1'b0, 12'h333, 3'd5, 1'b0, 1'b0);
        #2 check("lit_trap_cond_true", 32'(bus.seq_op), 1);
        tick();
        bus.cond = 8'h00;
        #2 check("lit_trap_cond_false", 32'(bus.seq_op), 2);
        tick();
        bus.trap_req = 1'b0;
        reset_pulse();

        // Underflow
        drive(2'd3, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
        #2 expect_hold("lit_unf_hold");
        tick();
        check("lit_unf_fault", 32'(bus.fault), 2);
        reset_pulse();

        // Call at depth 3 with a pending trap
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 1'b0, 12'h500 + 12'(i), 3'd0, 1'b0, 1'b0);
            tick();
        end
        bus.trap_req = 1'b1;
        drive(2'd2, 1'b0, 12'h456, 3'd0, 1'b0, 1'b0);
        #2 check("lit_call_over_trap", {bus.seq_op, bus.seq_din}, {2'd2, 12'h456});
        tick();
        check("lit_call4_depth_ack", {29'd0, bus.trap_ack, bus.depth}, {29'd0, 1'b0, 3'd4});
        drive(2'd0, 1'b0, 12'h457, 3'd0, 1'b0, 1'b0);
        #2 check("lit_full_no_trap", 32'(bus.seq_op), 0);
        tick();
        bus.trap_req = 1'b0;

        // Relative wrap-around passes straight through
        drive(2'd1, 1'b1, 12'hFFE, 3'd0, 1'b0, 1'b0);
        #2 check("lit_rel_wrap", {bus.seq_op, bus.seq_rel, bus.seq_din}, {2'd1, 1'b1, 12'hFFE});
        tick();
        reset_pulse();

        // Reset in the middle of a trap handler
        bus.trap_req = 1'b1;
        drive(2'd0, 1'b0, 12'h600, 3'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #2 check("lit_midtrap_rst", {29'd0, bus.trap_ack, bus.depth}, 0);
        tick();
        reset = 1'b1;
        #2 check("lit_trap_after_rst", 32'(bus.seq_op), 2);
        tick();
        bus.trap_req = 1'b0;

        // Reset in the middle of a stall
        drive(2'd0, 1'b0, 12'h700, 3'd0, 1'b0, 1'b1);
        bus.wait_req = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus.wait_req = 1'b0;
        #2 check("lit_midstall_rst", 32'(bus.seq_op), 0);
        tick();
        reset = 1'b1;
        drive(2'd0, 1'b0, 12'h701, 3'd0, 1'b0, 1'b0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
